tdm_demux4: RTL and testbench

Four-lane time-division demultiplexer: the receiving end of a 4:1 TDM link, where a 4:1 mux serialises four lanes onto one beat stream. It accepts one beat per valid cycle, aligns to the start-of-frame marker, and distributes slots 0..3 to four lane registers. Completed frames are committed atomically. It sits between a serial/TDM link front end and per-lane consumer logic.

---
 rtl/tdm_demux_pkg.sv | 31 +++
 rtl/tdm_slot_ctr.sv | 29 ++
 rtl/tdm_demux4.sv | 202 ++++++++++++++++++++
 tb/tb_tdm_demux4.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_demux_pkg.sv
// Shared constants, state encoding and the beat parity helper for the
// tdm_demux4 four-lane TDM demultiplexer.
package tdm_demux_pkg;

   // Lanes per TDM frame and the width of the slot index that walks them.
   localparam int NUM_LANES = 4;
   localparam int SLOT_W    = 2;

   // Framing state: HUNT searches for a start-of-frame beat, LOCKED tracks
   // slot positions inside aligned frames.
   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } tdm_state_e;

   // Odd parity over payload plus parity bit: a good beat has an odd number
   // of ones across both fields.
   function automatic logic odd_parity_ok(input logic [31:0] data,
                                          input int unsigned width,
                                          input logic par);
      logic acc;
      acc = par;
      for (int unsigned i = 0; i < 32; i++) begin
         if (i < width) begin
            acc = acc ^ data[i];
         end
      end
      return acc;
   endfunction

endpackage : tdm_demux_pkg

// File: rtl/tdm_slot_ctr.sv
// Slot counter for tdm_demux4: a mod-4 position counter with increment
// enable, a synchronous load-to-1 used when a start-of-frame beat realigns
// the frame, and a synchronous clear back to slot 0.
// Priority when several controls are active: clr, then load1, then en.
module tdm_slot_ctr
   import tdm_demux_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              load1,
   input  logic              clr,
   output logic [SLOT_W-1:0] slot
);

   // Slot position register; wraps naturally from 3 to 0 on increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot <= '0;
      end else if (clr) begin
         slot <= '0;
      end else if (load1) begin
         slot <= SLOT_W'(1);
      end else if (en) begin
         slot <= slot + SLOT_W'(1);
      end
   end

endmodule : tdm_slot_ctr

// File: rtl/tdm_demux4.sv
// tdm_demux4: receive side of a 4:1 TDM link. Beats arrive one per valid
// cycle; a beat flagged in_sof is slot 0 of a frame. Slots 0..2 are held in
// staging registers and the whole frame is copied into lane_q in one step
// when the slot-3 beat arrives, so consumers never see a partial frame.
//
// Optional feature macro: TDM_DEMUX_PARITY_EN adds the in_par input and the
// par_err output, and drops any beat whose odd parity check fails.
//
// Handshake: the input side is valid-only. A beat is consumed in every cycle
// where in_valid is high; there is no backpressure, and in_sof/in_data/in_par
// carry no meaning while in_valid is low. frame_vld, sync_err and par_err are
// single-cycle pulses with no ready; the consumer must sample them.
module tdm_demux4
   import tdm_demux_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        in_valid,
   input  logic [DATA_W-1:0]           in_data,
   input  logic                        in_sof,
`ifdef TDM_DEMUX_PARITY_EN
   input  logic                        in_par,
   output logic                        par_err,
`endif
   output logic [NUM_LANES*DATA_W-1:0] lane_q,
   output logic                        frame_vld,
   output logic                        locked,
   output logic                        sync_err,
   output tdm_state_e                  state_dbg
);

   tdm_state_e               state_q;
   tdm_state_e               state_d;
   logic [SLOT_W-1:0]        slot;

   // Slot-counter controls.
   logic                     ctr_en;
   logic                     ctr_load1;
   logic                     ctr_clr;

   // Staging write: store_en writes in_data into staging slot store_slot.
   logic                     store_en;
   logic [SLOT_W-1:0]        store_slot;
   logic [DATA_W-1:0]        stage0_q;
   logic [DATA_W-1:0]        stage1_q;
   logic [DATA_W-1:0]        stage2_q;

   // Frame commit and error pulses, one cycle ahead of the registered outputs.
   logic                     commit;
   logic                     sync_err_d;

`ifdef TDM_DEMUX_PARITY_EN
   logic                     par_ok;
   logic                     par_err_d;

   // Parity of the incoming beat; only meaningful while in_valid is high.
   always_comb begin
      par_ok = odd_parity_ok(32'(in_data), DATA_W, in_par);
   end
`endif

   tdm_slot_ctr u_slot_ctr (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (ctr_en),
      .load1 (ctr_load1),
      .clr   (ctr_clr),
      .slot  (slot)
   );

   // Framing state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= HUNT;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state, slot-counter control, staging write, commit and error decode.
   always_comb begin
      state_d    = state_q;
      ctr_en     = 1'b0;
      ctr_load1  = 1'b0;
      ctr_clr    = 1'b0;
      store_en   = 1'b0;
      store_slot = slot;
      commit     = 1'b0;
      sync_err_d = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      par_err_d  = 1'b0;

      // A corrupt beat throws away any partial frame and forces a re-hunt;
      // a corrupt sof beat therefore never achieves lock.
      if (in_valid && !par_ok) begin
         par_err_d = 1'b1;
         state_d   = HUNT;
         ctr_clr   = 1'b1;
      end else
`endif
      if (in_valid) begin
         unique case (state_q)
            HUNT: begin
               // Only a sof beat can start alignment; everything else drops.
               if (in_sof) begin
                  store_en   = 1'b1;
                  store_slot = '0;
                  ctr_load1  = 1'b1;
                  state_d    = LOCKED;
               end
            end
            LOCKED: begin
               if (slot == '0) begin
                  if (in_sof) begin
                     store_en   = 1'b1;
                     store_slot = '0;
                     ctr_load1  = 1'b1;
                  end else begin
                     // Expected a frame start and did not get one: lose lock.
                     sync_err_d = 1'b1;
                     ctr_clr    = 1'b1;
                     state_d    = HUNT;
                  end
               end else if (in_sof) begin
                  // Early sof: abandon the partial frame and realign on this
                  // beat without leaving LOCKED.
                  sync_err_d = 1'b1;
                  store_en   = 1'b1;
                  store_slot = '0;
                  ctr_load1  = 1'b1;
               end else if (slot == SLOT_W'(NUM_LANES - 1)) begin
                  // Last slot: the beat goes straight into lane_q with the
                  // staged slots; the counter wraps to 0.
                  commit = 1'b1;
                  ctr_en = 1'b1;
               end else begin
                  store_en = 1'b1;
                  ctr_en   = 1'b1;
               end
            end
            default: begin
               state_d = HUNT;
               ctr_clr = 1'b1;
            end
         endcase
      end
   end

   // Staging registers for slots 0..2; slot 3 never needs staging.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage0_q <= '0;
         stage1_q <= '0;
         stage2_q <= '0;
      end else if (store_en) begin
         unique case (store_slot)
            2'd0:    stage0_q <= in_data;
            2'd1:    stage1_q <= in_data;
            2'd2:    stage2_q <= in_data;
            default: ;
         endcase
      end
   end

   // Committed frame: updated atomically only on a slot-3 beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lane_q <= '0;
      end else if (commit) begin
         lane_q <= {in_data, stage2_q, stage1_q, stage0_q};
      end
   end

   // Registered single-cycle status pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_vld <= 1'b0;
         sync_err  <= 1'b0;
      end else begin
         frame_vld <= commit;
         sync_err  <= sync_err_d;
      end
   end

`ifdef TDM_DEMUX_PARITY_EN
   // Registered parity-failure pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         par_err <= 1'b0;
      end else begin
         par_err <= par_err_d;
      end
   end
`endif

   // locked is a direct decode of the registered state, so it is glitch-free.
   assign locked    = (state_q == LOCKED);
   assign state_dbg = state_q;

endmodule : tdm_demux4

// File: tb/tb_tdm_demux4.sv
// Directed testbench for tdm_demux4 (DATA_W=8). Frames are driven beat by
// beat with hand-computed expectations; a frame monitor pops an expected
// queue on each frame_vld pulse. Build with TDM_DEMUX_PARITY_EN defined to
// also exercise the parity path.
module tb_tdm_demux4;
   import tdm_demux_pkg::*;

   localparam int W = 8;

   logic            clk;
   logic            rst_n;
   logic            in_valid;
   logic [W-1:0]    in_data;
   logic            in_sof;
`ifdef TDM_DEMUX_PARITY_EN
   logic            in_par;
   logic            par_err;
`endif
   logic [4*W-1:0]  lane_q;
   logic            frame_vld;
   logic            locked;
   logic            sync_err;
   tdm_state_e      state_dbg;

   int n_chk = 0;
   int n_bad = 0;
   logic [4*W-1:0] exp_q[$];

   tdm_demux4 #(.DATA_W(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_sof    (in_sof),
`ifdef TDM_DEMUX_PARITY_EN
      .in_par    (in_par),
      .par_err   (par_err),
`endif
      .lane_q    (lane_q),
      .frame_vld (frame_vld),
      .locked    (locked),
      .sync_err  (sync_err),
      .state_dbg (state_dbg)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic do_reset();
      @(negedge clk);
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_sof   = 1'b0;
      in_data  = '0;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Outputs after the most recent sampled beat.
   task automatic expect_outs(input string tag, input logic fv, input logic se, input logic lk);
      chk({tag, "_frame_vld"}, 32'(frame_vld), 32'(fv));
      chk({tag, "_sync_err"},  32'(sync_err),  32'(se));
      chk({tag, "_locked"},    32'(locked),    32'(lk));
   endtask

   // ---------------- drivers ----------------
   // Drive one beat at the falling edge; return 1ns after the sampling edge.
   task automatic send(input logic sof, input logic [W-1:0] data, input logic bad_par = 1'b0);
      @(negedge clk);
      in_valid = 1'b1;
      in_sof   = sof;
      in_data  = data;
`ifdef TDM_DEMUX_PARITY_EN
      in_par   = (~^data) ^ bad_par;
`else
      if (bad_par) $display("note: parity request ignored in this build");
`endif
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_sof   = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         in_valid = 1'b0;
         in_sof   = 1'b0;
         @(posedge clk);
         #1;
      end
   endtask

   // ---------------- frame scoreboard ----------------
   always begin
      @(posedge clk);
      #1;
      if (rst_n && frame_vld) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_frame", 32'(frame_vld), 32'd0);
         end else begin
            chk("frame_data", lane_q, exp_q.pop_front());
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_sof   = 1'b0;
      in_data  = '0;
`ifdef TDM_DEMUX_PARITY_EN
      in_par   = 1'b0;
`endif
      do_reset();

      // Reset state
      expect_outs("rst", 1'b0, 1'b0, 1'b0);
      chk("rst_lane_q", lane_q, 32'h0);
      chk("rst_state", 32'(state_dbg), 32'(HUNT));
`ifdef TDM_DEMUX_PARITY_EN
      chk("rst_par_err", 32'(par_err), 32'd0);
`endif

      // Basic frame, consecutive beats
      send(1'b1, 8'h11); expect_outs("b0", 1'b0, 1'b0, 1'b1);
      chk("b0_state", 32'(state_dbg), 32'(LOCKED));
      send(1'b0, 8'h22); expect_outs("b1", 1'b0, 1'b0, 1'b1);
      send(1'b0, 8'h33); expect_outs("b2", 1'b0, 1'b0, 1'b1);
      chk("b2_lane_q_hidden", lane_q, 32'h0);
      exp_q.push_back(32'h44332211);
      send(1'b0, 8'h44); expect_outs("b3", 1'b1, 1'b0, 1'b1);
      chk("b3_lane_q", lane_q, 32'h44332211);
      idle(1); chk("b_after_fv", 32'(frame_vld), 32'd0);

      // Back-to-back frames: frame_vld on every 4th beat only
      exp_q.push_back(32'h04030201);
      exp_q.push_back(32'h08070605);
      for (int i = 0; i < 8; i++) begin
         send(i % 4 == 0, W'(i + 1));
         chk($sformatf("btb%0d_fv", i), 32'(frame_vld), 32'(i % 4 == 3));
      end
      chk("btb_lane_q", lane_q, 32'h08070605);

      // Gapped frame: two idle cycles between beats
      exp_q.push_back(32'h44332211);
      send(1'b1, 8'h11); idle(2); expect_outs("g0", 1'b0, 1'b0, 1'b1);
      send(1'b0, 8'h22); idle(2); expect_outs("g1", 1'b0, 1'b0, 1'b1);
      send(1'b0, 8'h33); idle(2); expect_outs("g2", 1'b0, 1'b0, 1'b1);
      send(1'b0, 8'h44); expect_outs("g3", 1'b1, 1'b0, 1'b1);
      chk("g3_lane_q", lane_q, 32'h44332211);
      idle(2); expect_outs("g_tail", 1'b0, 1'b0, 1'b1);

      // Early sof realigns the frame, partial frame dropped
      send(1'b1, 8'h01); expect_outs("r0", 1'b0, 1'b0, 1'b1);
      send(1'b0, 8'h02); expect_outs("r1", 1'b0, 1'b0, 1'b1);
      send(1'b1, 8'hA0); expect_outs("r_realign", 1'b0, 1'b1, 1'b1);
      chk("r_realign_lane_q", lane_q, 32'h44332211);
      send(1'b0, 8'hB0); expect_outs("r_b0", 1'b0, 1'b0, 1'b1);
      send(1'b0, 8'hC0); expect_outs("r_c0", 1'b0, 1'b0, 1'b1);
      exp_q.push_back(32'hD0C0B0A0);
      send(1'b0, 8'hD0); expect_outs("r_d0", 1'b1, 1'b0, 1'b1);
      chk("r_lane_q", lane_q, 32'hD0C0B0A0);

      // No sof after reset: stays in HUNT
      do_reset();
      send(1'b0, 8'h55); expect_outs("h55", 1'b0, 1'b0, 1'b0);
      send(1'b0, 8'h66); expect_outs("h66", 1'b0, 1'b0, 1'b0);
      send(1'b0, 8'h77); expect_outs("h77", 1'b0, 1'b0, 1'b0);
      chk("h_lane_q", lane_q, 32'h0);
      // sof without valid has no effect
      @(negedge clk); in_sof = 1'b1; in_valid = 1'b0;
      @(posedge clk); #1; in_sof = 1'b0;
      chk("sof_novalid_locked", 32'(locked), 32'd0);

      // Missing sof at slot 0 after a good frame
      exp_q.push_back(32'h44332211);
      send(1'b1, 8'h11); send(1'b0, 8'h22); send(1'b0, 8'h33); send(1'b0, 8'h44);
      chk("m_frame_vld", 32'(frame_vld), 32'd1);
      send(1'b0, 8'h99); expect_outs("m_nosof", 1'b0, 1'b1, 1'b0);
      chk("m_lane_q", lane_q, 32'h44332211);
      chk("m_state", 32'(state_dbg), 32'(HUNT));
      idle(1); expect_outs("m_tail", 1'b0, 1'b0, 1'b0);

`ifdef TDM_DEMUX_PARITY_EN
      // Bad parity on slot 1 drops the frame and loses lock
      send(1'b1, 8'h11); expect_outs("p0", 1'b0, 1'b0, 1'b1);
      send(1'b0, 8'h22, 1'b1);
      expect_outs("p_bad", 1'b0, 1'b0, 1'b0);
      chk("p_bad_par_err", 32'(par_err), 32'd1);
      send(1'b0, 8'h33); expect_outs("p2", 1'b0, 1'b0, 1'b0);
      chk("p2_par_err", 32'(par_err), 32'd0);
      send(1'b0, 8'h44); expect_outs("p3", 1'b0, 1'b0, 1'b0);
      chk("p_lane_q", lane_q, 32'h44332211);
      // Bad-parity sof in HUNT does not lock
      send(1'b1, 8'h5A, 1'b1); expect_outs("p_sof", 1'b0, 1'b0, 1'b0);
      chk("p_sof_par_err", 32'(par_err), 32'd1);
`endif

      // Reset asserted mid-frame after slot 2
      send(1'b1, 8'h11); send(1'b0, 8'h22); send(1'b0, 8'h33);
      chk("mr_pre_locked", 32'(locked), 32'd1);
      rst_n = 1'b0;
      #2;
      expect_outs("mr", 1'b0, 1'b0, 1'b0);
      chk("mr_lane_q", lane_q, 32'h0);
      chk("mr_state", 32'(state_dbg), 32'(HUNT));
`ifdef TDM_DEMUX_PARITY_EN
      chk("mr_par_err", 32'(par_err), 32'd0);
`endif
      @(negedge clk); rst_n = 1'b1;
      send(1'b0, 8'h44); expect_outs("mr_after", 1'b0, 1'b0, 1'b0);
      chk("mr_after_lane_q", lane_q, 32'h0);

      idle(2);
      chk("frames_outstanding", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

   // Hard time limit so the run always terminates.
   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule : tb_tdm_demux4
